// File: rtl/key_dispatch_ctrl.sv
// RSA public-key dispatch sequencer: keygen trigger, (n,e) validation with bounded retry,
// request/accept handshake with timeout, and rekey on demand. All outputs are registered.
module key_dispatch_ctrl #(
  parameter int KEY_WIDTH      = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 rekey,
  output logic                 kg_start,
  input  logic                 kg_done,
  input  logic [KEY_WIDTH-1:0] n_wire,
  input  logic [KEY_WIDTH-1:0] e_wire,
  output logic                 request,
  input  logic                 accept,
  output logic [KEY_WIDTH-1:0] n,
  output logic [KEY_WIDTH-1:0] e,
  output logic                 de_en,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           state_o
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYGEN = 3'd1,
    S_CHECK  = 3'd2,
    S_REQ    = 3'd3,
    S_ACTIVE = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t               r_state;
  logic [RW-1:0]        r_retry;
  logic [TW-1:0]        r_tmo;
  logic [KEY_WIDTH-1:0] r_key_n, r_key_e, r_n, r_e;
  logic                 r_kg_start, r_request, r_de_en, r_busy, r_error;

  state_t               w_state_nxt;
  logic [RW-1:0]        w_retry_nxt;
  logic [TW-1:0]        w_tmo_nxt;
  logic [KEY_WIDTH-1:0] w_key_n_nxt, w_key_e_nxt, w_n_nxt, w_e_nxt;
  logic                 w_key_ok;

  assign w_key_ok = r_key_n[0] && (r_key_n != KEY_WIDTH'(1)) &&
                    (r_key_e != '0) && (r_key_e < r_key_n);

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_tmo_nxt   = r_tmo;
    w_key_n_nxt = r_key_n;
    w_key_e_nxt = r_key_e;
    w_n_nxt     = r_n;
    w_e_nxt     = r_e;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_state_nxt = S_KEYGEN;
          w_retry_nxt = '0;
        end
      end
      S_KEYGEN: begin
        if (kg_done) begin
          w_key_n_nxt = n_wire;
          w_key_e_nxt = e_wire;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_key_ok) begin
          w_state_nxt = S_REQ;
          w_tmo_nxt   = '0;
        end else if (r_retry < RW'(MAX_RETRY)) begin
          w_retry_nxt = r_retry + RW'(1);
          w_state_nxt = S_KEYGEN;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_REQ: begin
        w_tmo_nxt = r_tmo + TW'(1);
        // accept takes priority over a timeout landing on the same edge
        if (accept) begin
          w_n_nxt     = r_key_n;
          w_e_nxt     = r_key_e;
          w_retry_nxt = '0;
          w_state_nxt = S_ACTIVE;
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ACTIVE: begin
        if (rekey) w_state_nxt = S_KEYGEN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_retry    <= '0;
      r_tmo      <= '0;
      r_key_n    <= '0;
      r_key_e    <= '0;
      r_n        <= '0;
      r_e        <= '0;
      r_kg_start <= 1'b0;
      r_request  <= 1'b0;
      r_de_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_retry    <= w_retry_nxt;
      r_tmo      <= w_tmo_nxt;
      r_key_n    <= w_key_n_nxt;
      r_key_e    <= w_key_e_nxt;
      r_n        <= w_n_nxt;
      r_e        <= w_e_nxt;
      // pulse only on the entry edge into KEYGEN, including retries from CHECK
      r_kg_start <= (w_state_nxt == S_KEYGEN) && (r_state != S_KEYGEN);
      r_request  <= (w_state_nxt == S_REQ);
      r_de_en    <= (w_state_nxt == S_ACTIVE);
      r_busy     <= (w_state_nxt == S_KEYGEN) || (w_state_nxt == S_CHECK) ||
                    (w_state_nxt == S_REQ);
      r_error    <= (w_state_nxt == S_ERR);
    end
  end

  assign kg_start = r_kg_start;
  assign request  = r_request;
  assign n        = r_n;
  assign e        = r_e;
  assign de_en    = r_de_en;
  assign busy     = r_busy;
  assign error    = r_error;
  assign state_o  = r_state;

endmodule
